tile_stim_capture: RTL
======================

// Module: tile_stim_capture
// PURPOSE
// - On-chip stimulus/response engine for a microtile: drives the tile's ui_in bus and
//   samples its uo_out bus, the reverse of a bench that only wires ui_in/uo_out.
// - Generates NVEC input vectors (counter or LFSR), waits SETTLE cycles per vector and
//   folds every sampled uo_out into a 16-bit MISR signature.
// - Compares the signature against an expected value; used for self-test of Wokwi tiles.
// PARAMETERS
// - NVEC    256    vectors per run, 1..256
// - SETTLE  2      extra hold cycles before sampling, 0..15; each vector lasts SETTLE+1 cycles
// - SEED    8'h01  LFSR start value (nonzero)
// PORTS
// - clk      in   1   single clock, all state on rising edge
// - rst_n    in   1   asynchronous, active-low reset
// - start    in   1   run request, sampled only in IDLE or DONE
// - mode     in   1   0 = counter vectors 0,1,2..; 1 = LFSR vectors; latched at start
// - exp_sig  in   16  expected signature, compared when the run ends
// - uo_out   in   8   tile outputs under test
// - ui_in    out  8   tile inputs being driven
// - busy     out  1   run in progress
// - done     out  1   run finished; held until next accepted start
// - pass     out  1   signature == exp_sig; valid while done=1
// - signature out 16  MISR contents
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, ui_in=0, busy=0, done=0, pass=0, signature=0, vec index=0.
// - States: IDLE -> RUN -> DONE -> RUN (on start) ...; RUN has an internal settle counter.
// - Accept: on edge E0 with start=1 in IDLE/DONE: latch mode, clear signature to 0, busy=1,
//   done=0, pass=0, ui_in=vector0 (0 in counter mode, SEED in LFSR mode), settle cnt=0.
// - start while busy=1 is ignored.
// - RUN: ui_in stable for SETTLE+1 cycles per vector. On the final edge of each window,
//   signature <= {1'b0,sig[15:1]} ^ (sig[0] ? 16'hB400 : 0) ^ {8'h00,uo_out}.
// - Same edge: if vec index < NVEC-1, ui_in <= next vector, index++, settle cnt=0.
// - Counter next = ui_in+1 (wraps 255->0).
// - LFSR next = {1'b0,v[7:1]} ^ (v[0] ? 8'hB8 : 0); from 01 gives B8,5C,2E,..
// - Last vector: the sampling edge moves to DONE. busy=0, done=1, ui_in=0,
//   pass=(next signature==exp_sig).
// - Latency: done rises on edge E0 + NVEC*(SETTLE+1).
// - DONE: outputs hold; exp_sig changes after done do not alter pass.
// - NVEC=1: a single window, then DONE. SETTLE=0: a new vector every cycle.
// - Reset mid-run: immediate return to reset values; a partial signature is discarded.
// - Simultaneous start and rst_n=0: reset wins.
// TESTING
// - Loopback uo_out=ui_in, mode=0, NVEC=3, SETTLE=2, start@E0
//   -> ui_in 0,1,2 each 3 cycles; done@E0+9; signature=16'hB402.
// - uo_out tied 8'h00, NVEC=256, SETTLE=0, exp_sig=0 -> done@E0+256, signature=0, pass=1.
// - mode=1, NVEC=4, SETTLE=0 -> ui_in sequence 01,B8,5C,2E on consecutive cycles.
// - Loopback run with exp_sig=16'hB403 -> done=1, pass=0, signature=16'hB402.
// - start pulsed again mid-run -> ignored, same timing/signature as the undisturbed run.
// - rst_n low at E0+4 of a 9-cycle run -> all outputs 0 asynchronously; new start completes normally.

Source files
------------

// File: rtl/tile_stim_capture.sv
// tile_stim_capture: on-chip stimulus/response engine for a microtile.
// Drives NVEC vectors (counter or LFSR) onto ui_in, holds each for SETTLE+1
// cycles, folds the uo_out seen on the last cycle of every window into a
// 16-bit MISR and compares the final signature against exp_sig.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           run request, honoured only when idle or done
//   mode            0 = counter vectors, 1 = LFSR vectors (latched at start)
//   exp_sig[15:0]   expected signature, compared on the last sampling edge
//   uo_out[7:0]     tile outputs under test
//   ui_in[7:0]      tile inputs being driven
//   busy, done      run in progress / run finished (held until next start)
//   pass            signature matched exp_sig; meaningful while done=1
//   signature[15:0] MISR contents
module tile_stim_capture #(
    parameter int unsigned NVEC   = 256,
    parameter int unsigned SETTLE = 2,
    parameter logic [7:0]  SEED   = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] exp_sig,
    input  logic [7:0]  uo_out,
    output logic [7:0]  ui_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam int unsigned IDX_W = (NVEC > 1) ? $clog2(NVEC) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NVEC - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SETTLE);
    localparam logic [15:0]      MISR_POLY = 16'hB400;
    localparam logic [7:0]       LFSR_POLY = 8'hB8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       ui_d;
    logic             busy_d, done_d, pass_d;
    logic [15:0]      sig_d;
    logic [15:0]      sig_next;
    logic [7:0]       vec_next;

    // MISR fold of the current tile response and next stimulus vector
    always_comb begin
        sig_next = {1'b0, signature[15:1]}
                 ^ (signature[0] ? MISR_POLY : 16'h0000)
                 ^ {8'h00, uo_out};
        if (mode_q) begin
            vec_next = {1'b0, ui_in[7:1]} ^ (ui_in[0] ? LFSR_POLY : 8'h00);
        end else begin
            vec_next = ui_in + 8'd1;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ui_d    = ui_in;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        sig_d   = signature;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ui_d    = mode ? SEED : 8'h00;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    sig_d   = 16'h0000;
                end
            end
            S_RUN: begin
                if (cnt_q == LAST_CNT) begin
                    // last cycle of the window: sample and advance
                    sig_d = sig_next;
                    cnt_d = '0;
                    if (idx_q != LAST_IDX) begin
                        ui_d  = vec_next;
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        state_d = S_DONE;
                        ui_d    = 8'h00;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (sig_next == exp_sig);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            ui_in     <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= 16'h0000;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            ui_in     <= ui_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            signature <= sig_d;
        end
    end

endmodule
